// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Buffered UART transmitter. Words enter an internal FIFO over
//                a valid/ready stream and are serialised LSB-first on tx with
//                a start bit, DATA_BITS data bits, optional parity and
//                STOP_BITS stop bits. Frames are sent back-to-back while the
//                FIFO holds data.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous reset, active low
//                data       - word to transmit (DATA_BITS wide)
//                data_valid - data is valid
//                data_ready - FIFO accepts a word this cycle
//                tx         - serial line, idle high, registered
//                busy       - FIFO non-empty or frame in progress
//                fifo_count - words queued, excluding the word being shifted
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int c_CW     = (c_PERIOD > 1) ? $clog2(c_PERIOD) : 1;
    localparam int c_AW     = $clog2(FIFO_DEPTH);

    localparam logic [c_CW-1:0] c_CNT_MAX   = c_CW'(c_PERIOD - 1);
    localparam logic [3:0]      c_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      c_STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [c_AW:0]   c_DEPTH     = (c_AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_AW:0]        r_count;
    logic                 r_ready_en;   // keeps data_ready low until the first edge after reset

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;

    assign w_full     = (r_count == c_DEPTH);
    assign w_empty    = (r_count == '0);
    assign data_ready = r_ready_en && !w_full;
    assign w_push     = data_valid && data_ready;
    assign w_head     = r_mem[r_rd_ptr];
    // Odd parity inverts the XOR so the total count of ones is odd.
    assign w_head_par = (PARITY == 1) ? ~^w_head : ^w_head;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [c_CW-1:0]      r_cnt;
    logic [3:0]           r_bit;      // data bit index, reused as stop bit index
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;

    logic [2:0]           w_state_nxt;
    logic [c_CW-1:0]      w_cnt_nxt;
    logic [3:0]           w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_par_nxt;
    logic                 w_tx_nxt;
    logic                 w_adv;

    assign w_adv = (r_cnt == c_CNT_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;

        case (r_state)
            c_ST_IDLE: begin
                w_cnt_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                if (w_adv) begin
                    w_state_nxt = c_ST_DATA;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                end
            end
            c_ST_DATA: begin
                if (w_adv) begin
                    w_cnt_nxt = '0;
                    if (r_bit == c_DATA_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (PARITY != 0) ? c_ST_PARITY : c_ST_STOP;
                    end else begin
                        w_bit_nxt   = r_bit + 1'b1;
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
            c_ST_PARITY: begin
                if (w_adv) begin
                    w_state_nxt = c_ST_STOP;
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                end
            end
            c_ST_STOP: begin
                if (w_adv) begin
                    w_cnt_nxt = '0;
                    if (r_bit == c_STOP_LAST) begin
                        w_bit_nxt = '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_state_nxt = c_ST_START;
                        end else begin
                            w_state_nxt = c_ST_IDLE;
                        end
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (w_pop) begin
            w_shift_nxt = w_head;
            w_par_nxt   = w_head_par;
            w_cnt_nxt   = '0;
        end

        // tx is registered, so it is decoded from the next state.
        case (w_state_nxt)
            c_ST_START:  w_tx_nxt = 1'b0;
            c_ST_DATA:   w_tx_nxt = w_shift_nxt[0];
            c_ST_PARITY: w_tx_nxt = w_par_nxt;
            default:     w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    assign tx         = r_tx;
    assign busy       = (r_state != c_ST_IDLE) || !w_empty;
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Directed self-checking bench for uart_tx_fifo. Four DUT
//                instances (PERIOD=4) cover 8N1, 7E1, 7O1 and a 4-deep FIFO
//                with two stop bits; one instance is selected at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic        clk;
    logic        r_rst;
    logic [7:0]  r_din;
    logic        r_valid;
    int          r_sel;
    logic        r_acc;
    int          n_checks;
    int          n_fail;

    logic        w_rdy_a, w_tx_a, w_busy_a;
    logic        w_rdy_b, w_tx_b, w_busy_b;
    logic        w_rdy_c, w_tx_c, w_busy_c;
    logic        w_rdy_d, w_tx_d, w_busy_d;
    logic [4:0]  w_cnt_a, w_cnt_b, w_cnt_c;
    logic [2:0]  w_cnt_d;

    logic        w_tx_s, w_rdy_s, w_busy_s;
    logic [31:0] w_cnt_s;

    uart_tx_fifo #(.CLK_FREQ(4), .BAUD_RATE(1)) u_a (
        .clk(clk), .rst(r_rst), .data(r_din), .data_valid(r_valid && r_sel == 0),
        .data_ready(w_rdy_a), .tx(w_tx_a), .busy(w_busy_a), .fifo_count(w_cnt_a));

    uart_tx_fifo #(.CLK_FREQ(4), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(2)) u_b (
        .clk(clk), .rst(r_rst), .data(r_din[6:0]), .data_valid(r_valid && r_sel == 1),
        .data_ready(w_rdy_b), .tx(w_tx_b), .busy(w_busy_b), .fifo_count(w_cnt_b));

    uart_tx_fifo #(.CLK_FREQ(4), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(1)) u_c (
        .clk(clk), .rst(r_rst), .data(r_din[6:0]), .data_valid(r_valid && r_sel == 2),
        .data_ready(w_rdy_c), .tx(w_tx_c), .busy(w_busy_c), .fifo_count(w_cnt_c));

    uart_tx_fifo #(.CLK_FREQ(4), .BAUD_RATE(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_d (
        .clk(clk), .rst(r_rst), .data(r_din), .data_valid(r_valid && r_sel == 3),
        .data_ready(w_rdy_d), .tx(w_tx_d), .busy(w_busy_d), .fifo_count(w_cnt_d));

    always_comb begin
        w_tx_s   = 1'b1;
        w_rdy_s  = 1'b0;
        w_busy_s = 1'b0;
        w_cnt_s  = '0;
        case (r_sel)
            0: begin w_tx_s = w_tx_a; w_rdy_s = w_rdy_a; w_busy_s = w_busy_a; w_cnt_s = 32'(w_cnt_a); end
            1: begin w_tx_s = w_tx_b; w_rdy_s = w_rdy_b; w_busy_s = w_busy_b; w_cnt_s = 32'(w_cnt_b); end
            2: begin w_tx_s = w_tx_c; w_rdy_s = w_rdy_c; w_busy_s = w_busy_c; w_cnt_s = 32'(w_cnt_c); end
            default: begin w_tx_s = w_tx_d; w_rdy_s = w_rdy_d; w_busy_s = w_busy_d; w_cnt_s = 32'(w_cnt_d); end
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at the negedge after the pop edge; bits[0] is the start bit.
    // Each bit is sampled on its four clocks and must be stable.
    task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits);
        logic [3:0] obs;
        for (int b = 0; b < nbits; b++) begin
            for (int j = 0; j < 4; j++) begin
                obs[j] = w_tx_s;
                @(negedge clk);
            end
            chk($sformatf("%s_bit%0d", tag, b), {28'd0, obs}, bits[b] ? 32'hF : 32'h0);
        end
    endtask

    task automatic push1(input logic [7:0] d);
        r_din   = d;
        r_valid = 1'b1;
        @(negedge clk);
        r_valid = 1'b0;
    endtask

    initial begin
        int lows;
        n_checks = 0;
        n_fail   = 0;
        r_rst    = 1'b0;
        r_din    = '0;
        r_valid  = 1'b0;
        r_sel    = 0;
        r_acc    = 1'b0;

        // Reset state of every instance
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            r_sel = s;
            #1;
            chk($sformatf("rst_tx%0d", s), 32'(w_tx_s), 32'd1);
            chk($sformatf("rst_rdy%0d", s), 32'(w_rdy_s), 32'd0);
            chk($sformatf("rst_busy%0d", s), 32'(w_busy_s), 32'd0);
            chk($sformatf("rst_cnt%0d", s), w_cnt_s, 32'd0);
        end
        r_sel = 0;
        @(negedge clk);
        r_rst = 1'b1;
        #1 chk("rdy_before_edge", 32'(w_rdy_s), 32'd0);
        @(negedge clk);
        chk("rdy_after_edge", 32'(w_rdy_s), 32'd1);

        // 8N1 single word 0x55
        push1(8'h55);
        chk("a55_cnt_push", w_cnt_s, 32'd1);
        chk("a55_busy_push", 32'(w_busy_s), 32'd1);
        chk("a55_tx_push", 32'(w_tx_s), 32'd1);
        @(negedge clk);
        chk("a55_tx_pop", 32'(w_tx_s), 32'd0);
        chk("a55_cnt_pop", w_cnt_s, 32'd0);
        check_frame("a55", {6'b0, 1'b1, 8'h55, 1'b0}, 10);
        chk("a55_busy_end", 32'(w_busy_s), 32'd0);
        chk("a55_tx_end", 32'(w_tx_s), 32'd1);
        repeat (3) @(negedge clk);

        // Three words on consecutive clocks, contiguous frames
        r_din   = 8'hA5;
        r_valid = 1'b1;
        @(negedge clk);
        chk("b2b_cnt1", w_cnt_s, 32'd1);
        r_din = 8'h3C;
        @(negedge clk);
        chk("b2b_cnt2", w_cnt_s, 32'd1);
        r_din = 8'hFF;
        fork
            begin
                @(negedge clk);
                r_valid = 1'b0;
                chk("b2b_cnt3", w_cnt_s, 32'd2);
            end
        join_none
        check_frame("a5", {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
        chk("b2b_cnt_f2", w_cnt_s, 32'd1);
        check_frame("3c", {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
        chk("b2b_cnt_f3", w_cnt_s, 32'd0);
        check_frame("ff", {6'b0, 1'b1, 8'hFF, 1'b0}, 10);
        chk("b2b_busy_end", 32'(w_busy_s), 32'd0);
        repeat (3) @(negedge clk);

        // 7E1: 0x07 has three ones -> parity 1
        r_sel = 1;
        push1(8'h07);
        @(negedge clk);
        check_frame("even07", {6'b0, 1'b1, 1'b1, 7'h07, 1'b0}, 10);
        chk("even_busy_end", 32'(w_busy_s), 32'd0);

        // 7O1: 0x07 -> parity 0
        r_sel = 2;
        push1(8'h07);
        @(negedge clk);
        check_frame("odd07", {6'b0, 1'b1, 1'b0, 7'h07, 1'b0}, 10);
        chk("odd_busy_end", 32'(w_busy_s), 32'd0);
        repeat (2) @(negedge clk);

        // 4-deep FIFO, two stop bits, data_valid held with incrementing data
        r_sel = 3;
        fork
            begin
                r_din   = 8'h10;
                r_valid = 1'b1;
                for (int i = 0; i < 1000; i++) begin
                    if (r_din == 8'h17) break;
                    r_acc = w_rdy_s;
                    @(negedge clk);
                    if (r_acc) r_din = r_din + 8'd1;
                end
                r_valid = 1'b0;
            end
            begin
                @(negedge clk); chk("full_cnt_t1", w_cnt_s, 32'd1);
                @(negedge clk); chk("full_cnt_t2", w_cnt_s, 32'd1);
                @(negedge clk); chk("full_cnt_t3", w_cnt_s, 32'd2);
                @(negedge clk); chk("full_cnt_t4", w_cnt_s, 32'd3);
                @(negedge clk); chk("full_cnt_t5", w_cnt_s, 32'd4);
                chk("full_rdy_low", 32'(w_rdy_s), 32'd0);
                repeat (41) @(negedge clk);
                chk("full_cnt_pop", w_cnt_s, 32'd3);
                chk("full_rdy_pop", 32'(w_rdy_s), 32'd1);
                @(negedge clk);
                chk("full_cnt_refill", w_cnt_s, 32'd4);
                chk("full_rdy_refill", 32'(w_rdy_s), 32'd0);
            end
        join_none
        repeat (2) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            check_frame($sformatf("d%0d", i), {5'b0, 2'b11, 8'(8'h10 + i), 1'b0}, 11);
        end
        chk("full_busy_end", 32'(w_busy_s), 32'd0);
        chk("full_cnt_end", w_cnt_s, 32'd0);
        chk("full_all_pushed", 32'(r_din), 32'h17);
        repeat (3) @(negedge clk);

        // Reset in DATA bit 3 with two words queued
        r_sel   = 0;
        r_din   = 8'h03;
        r_valid = 1'b1;
        @(negedge clk);
        r_din = 8'h33;
        @(negedge clk);
        r_din = 8'h44;
        @(negedge clk);
        r_valid = 1'b0;
        repeat (16) @(negedge clk);
        chk("mid_tx_low", 32'(w_tx_s), 32'd0);
        chk("mid_cnt", w_cnt_s, 32'd2);
        #2 r_rst = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(w_tx_s), 32'd1);
        chk("mid_rst_cnt", w_cnt_s, 32'd0);
        chk("mid_rst_busy", 32'(w_busy_s), 32'd0);
        chk("mid_rst_rdy", 32'(w_rdy_s), 32'd0);
        @(negedge clk);
        r_rst = 1'b1;
        #1 chk("rel_rdy_before", 32'(w_rdy_s), 32'd0);
        @(negedge clk);
        chk("rel_rdy_after", 32'(w_rdy_s), 32'd1);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            if (w_tx_s !== 1'b1 || w_busy_s !== 1'b0) lows++;
            @(negedge clk);
        end
        chk("rel_no_residual", 32'(lows), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
